// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-wide instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} fetch_state_t;

    localparam int          BYTES_PER_INSTR = 4;
    localparam int          INSTR_W         = 32;
    localparam logic [31:0] FAULT_INSTR     = 32'h0;

endpackage

// File: rtl/fetch_byte_packer.sv
// Big-endian word assembly register: the first byte shifted in ends up in the MSBs.
module fetch_byte_packer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clr) begin
            word <= FAULT_INSTR;
        end else if (shift_en) begin
            word <= {word[INSTR_W-9:0], byte_in};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one 32-bit instruction as four enable-pulsed byte reads from the instruction RAM.
// Optional one-entry last-word buffer enabled by defining FETCH_LAST_HIT_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_pc,
    input  logic               flush,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_fault,
    output logic               mem_enable,
    output logic               mem_rw,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_data,
    output logic               busy
);

    fetch_state_t       state;
    logic [1:0]         cnt;
    logic [1:0]         cnt_nxt;
    logic [ADDR_W-1:0]  base;
    logic               accept;
    logic               misaligned;
    logic               hit;
    logic [INSTR_W-1:0] pack_word;

    assign req_ready   = (state == IDLE) && !flush;
    assign accept      = req_valid && req_ready;
    assign misaligned  = (req_pc[1:0] != 2'b00);
    assign busy        = (state != IDLE);
    assign instr_valid = (state == DONE);
    assign instr_pc    = base;
    assign mem_rw      = 1'b1;
    assign cnt_nxt     = cnt + 2'd1;

    fetch_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .shift_en ((state == CAP) && !flush),
        .byte_in  (mem_data),
        .word     (pack_word)
    );

    // Enable is registered so each byte gets exactly one clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            base        <= '0;
            mem_enable  <= 1'b0;
            mem_addr    <= '0;
            instr_fault <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            mem_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base        <= req_pc;
                        cnt         <= 2'd0;
                        instr_fault <= misaligned;
                        if (misaligned || hit) begin
                            state <= DONE;
                        end else begin
                            state      <= REQ;
                            mem_enable <= 1'b1;
                            mem_addr   <= req_pc;
                        end
                    end
                end
                REQ: begin
                    state      <= CAP;
                    mem_enable <= 1'b0;
                end
                CAP: begin
                    if (cnt == 2'd3) begin
                        state <= DONE;
                    end else begin
                        cnt        <= cnt_nxt;
                        state      <= REQ;
                        mem_enable <= 1'b1;
                        mem_addr   <= base + ADDR_W'(cnt_nxt);
                    end
                end
                DONE: begin
                    if (instr_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_LAST_HIT_EN
    logic               lb_valid;
    logic [ADDR_W-1:0]  lb_pc;
    logic [INSTR_W-1:0] lb_instr;
    logic               hit_sel;

    assign hit   = lb_valid && (lb_pc == req_pc);
    assign instr = hit_sel ? lb_instr : pack_word;

    // Captures the final byte directly so the buffer is ready the cycle DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid <= 1'b0;
            lb_pc    <= '0;
            lb_instr <= '0;
            hit_sel  <= 1'b0;
        end else if (flush) begin
            lb_valid <= 1'b0;
        end else begin
            if (accept) hit_sel <= hit && !misaligned;
            if ((state == CAP) && (cnt == 2'd3)) begin
                lb_valid <= 1'b1;
                lb_pc    <= base;
                lb_instr <= {pack_word[INSTR_W-9:0], mem_data};
            end
        end
    end
`else
    assign hit   = 1'b0;
    assign instr = pack_word;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a byte-array model of the instruction RAM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_pc;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [8:0]  instr_pc;
    logic        instr_fault;
    logic        mem_enable;
    logic        mem_rw;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        busy;

    logic [7:0]  ram [512];
    logic [8:0]  addrs [$];
    logic        prev_en = 1'b0;
    logic        dbl = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign mem_data = ram[mem_addr];

    instr_fetch_unit #(.ADDR_W(9), .INSTR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pc      (req_pc),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .mem_enable  (mem_enable),
        .mem_rw      (mem_rw),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy)
    );

    // Log every read pulse; an enable held for two edges is a protocol error.
    always @(posedge clk) begin
        if (mem_enable) begin
            addrs.push_back(mem_addr);
            if (prev_en) dbl = 1'b1;
        end
        prev_en = mem_enable;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full request/response transaction; hold = cycles of backpressure on the result.
    task automatic fetch(input logic [8:0] pc, input int hold);
        logic [31:0] exp_i;
        logic [8:0]  a;
        logic [31:0] snap;
        bit          exp_f;
        int          lat;
        int          exp_n;
        exp_f = (pc % 4) != 0;
        exp_i = 32'h0;
        if (!exp_f) begin
            for (int k = 0; k < 4; k++) begin
                a     = pc + 9'(k);
                exp_i = {exp_i[23:0], ram[a]};
            end
        end
        exp_n = exp_f ? 0 : 4;
        addrs.delete();
        dbl = 1'b0;
        req_pc    = pc;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!instr_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_f ? 1 : 9);
        chk("instr", instr, exp_i);
        chk("instr_pc", instr_pc, pc);
        chk("instr_fault", instr_fault, exp_f);
        chk("n_reads", addrs.size(), exp_n);
        for (int k = 0; k < addrs.size() && k < 4; k++)
            chk("read_addr", addrs[k], pc + 9'(k));
        chk("single_pulse", dbl, 0);
        chk("mem_rw", mem_rw, 1);
        snap = instr;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", instr_valid, 1);
            chk("hold_instr", instr, snap);
            chk("hold_pc", instr_pc, pc);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
        end
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        chk("post_valid", instr_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        int guard;
        logic [8:0] rpc;
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h81; ram[1] = 8'hC3; ram[2] = 8'hE0; ram[3] = 8'h08;
        ram[508] = 8'hDE; ram[509] = 8'hAD; ram[510] = 8'hBE; ram[511] = 8'hEF;
        rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; instr_ready = 1'b0;

        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", instr_fault, 0);
        chk("rst_en", mem_enable, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rw", mem_rw, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fetch(9'd0, 0);
        chk("dir_instr0", instr_pc, 0);
        fetch(9'd508, 0);
        fetch(9'd2, 0);
        fetch(9'd12, 5);
        fetch(9'd0, 0);

        // Flush while the third byte read is being issued.
        addrs.delete();
        req_pc = 9'd16; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (addrs.size() < 2 && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        chk("flush_reach", guard < 20, 1);
        @(posedge clk);
        @(negedge clk);
        chk("flush_pre_en", mem_enable, 1);
        flush = 1'b1;
        chk("flush_req_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_en", mem_enable, 0);
        chk("flush_busy", busy, 0);
        chk("flush_valid", instr_valid, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("flush_no_valid", instr_valid, 0);
        end
        fetch(9'd4, 0);

        // Flush concurrent with a request: nothing is accepted.
        req_pc = 9'd20; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_busy", busy, 0);
        chk("flush_req_en", mem_enable, 0);

        // Flush in DONE together with instr_ready drops the result.
        req_pc = 9'd6; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("drop_valid_pre", instr_valid, 1);
        flush = 1'b1; instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; instr_ready = 1'b0;
        chk("drop_valid", instr_valid, 0);
        chk("drop_busy", busy, 0);

        // Asynchronous reset while a read is in flight.
        req_pc = 9'd8; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_pre_en", mem_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_en", mem_enable, 0);
        chk("rstmid_valid", instr_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_req_ready", req_ready, 1);
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            rpc = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            fetch(rpc, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
